// File: rtl/sync_ramif_dpram_if.sv
// Bus bundle between a FIFO's RAM-port outputs and the sync_ramif_dpram responder.
// The FIFO side uses the master modport; the RAM side uses the slave modport.
interface sync_ramif_dpram_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic [DSIZE-1:0] a_wdata;
    logic [ASIZE-1:0] a_addr;
    logic             a_rinc;
    logic             a_winc;
    logic [DSIZE-1:0] a_rdata;

    logic [DSIZE-1:0] b_wdata;
    logic [ASIZE-1:0] b_addr;
    logic             b_rinc;
    logic             b_winc;
    logic [DSIZE-1:0] b_rdata;

    modport master (
        output a_wdata, a_addr, a_rinc, a_winc,
        input  a_rdata,
        output b_wdata, b_addr, b_rinc, b_winc,
        input  b_rdata
    );

    modport slave (
        input  a_wdata, a_addr, a_rinc, a_winc,
        output a_rdata,
        input  b_wdata, b_addr, b_rinc, b_winc,
        output b_rdata
    );
endinterface

// File: rtl/sync_ramif_dpram.sv
// Single-clock two-port RAM responder for a FIFO, with post-reset clear and write-collision counting.
// Define SYNC_RAMIF_DPRAM_RDW_BYPASS_EN for write-first forwarding across ports; default is read-first.
module sync_ramif_dpram #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4,
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sync_ramif_dpram_if.slave    bus,
    output logic                 init_done,
    output logic                 wr_collision,
    output logic [CNTW-1:0]      collision_cnt
);
    localparam int DEPTH = 2 ** ASIZE;

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    state_e           state_q, state_d;
    logic [ASIZE-1:0] clr_addr_q;
    logic             clr_we;
    logic             a_we, b_we, collide;
    logic [DSIZE-1:0] a_rd_next, b_rd_next;
    logic [DSIZE-1:0] mem [DEPTH];

    // Read strobes carry no meaning here: reads are continuous look-ahead.
    logic unused_rinc;
    assign unused_rinc = bus.a_rinc ^ bus.b_rinc;

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        clr_we  = 1'b0;
        a_we    = 1'b0;
        b_we    = 1'b0;
        collide = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (&clr_addr_q) state_d = READY;
            end
            READY: begin
                collide = bus.a_winc & bus.b_winc & (bus.a_addr == bus.b_addr);
                a_we    = bus.a_winc;
                b_we    = bus.b_winc & ~collide;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        a_rd_next = mem[bus.a_addr];
        b_rd_next = mem[bus.b_addr];
`ifdef SYNC_RAMIF_DPRAM_RDW_BYPASS_EN
        if (b_we && (bus.b_addr == bus.a_addr)) a_rd_next = bus.b_wdata;
        if (a_we && (bus.a_addr == bus.b_addr)) b_rd_next = bus.a_wdata;
`endif
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= CLEAR;
            clr_addr_q    <= '0;
            init_done     <= 1'b0;
            wr_collision  <= 1'b0;
            collision_cnt <= '0;
            bus.a_rdata   <= '0;
            bus.b_rdata   <= '0;
        end else begin
            state_q      <= state_d;
            init_done    <= (state_d == READY);
            wr_collision <= collide;
            if (clr_we) clr_addr_q <= clr_addr_q + 1'b1;
            if (collide && (collision_cnt != {CNTW{1'b1}}))
                collision_cnt <= collision_cnt + 1'b1;
            if (state_q == READY) begin
                if (!bus.a_winc) bus.a_rdata <= a_rd_next;
                if (!bus.b_winc) bus.b_rdata <= b_rd_next;
            end
        end
    end

    // NOTE: the array has no reset branch; the clear sequencer zeroes it word by word after reset.
    // A is written last so it wins on a same-address collision (b_we is also masked then).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) mem[clr_addr_q]   <= '0;
            if (b_we)   mem[bus.b_addr]   <= bus.b_wdata;
            if (a_we)   mem[bus.a_addr]   <= bus.a_wdata;
        end
    end
endmodule
